// File: rtl/rgb2raw_8_pkg.sv
// Shared types for the RGB to raw8 Bayer re-mosaic path.
// Lane count follows MIPI_4_LANE; the default is the 2-lane word.
package rgb2raw_8_pkg;

`ifdef MIPI_4_LANE
    localparam int PIX_PER_WORD = 4;
`else
    localparam int PIX_PER_WORD = 2;
`endif

    localparam int LANE_W = 8 * PIX_PER_WORD;

    typedef logic [LANE_W-1:0] lane_raw_data_t;

    typedef enum logic [1:0] {
        BAYER_R,
        BAYER_G,
        BAYER_B
    } bayer_col_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LINE,
        ST_LGAP,
        ST_FGAP
    } rgb2raw_state_e;

endpackage

// File: rtl/rgb2raw_8_bayer_pick.sv
// GBRG colour pick: even rows G/B, odd rows R/G.
// Purely combinational, one 8-bit sample per pixel.
module bayer_pick
    import rgb2raw_8_pkg::*;
#(
    parameter int RGB_WIDTH = 24
) (
    input  logic                 row_odd,
    input  logic                 col_odd,
    input  logic [RGB_WIDTH-1:0] rgb,
    output logic [7:0]           pix
);

    bayer_col_e col;

    always_comb begin
        col = BAYER_G;
        unique case (1'b1)
            (!row_odd && col_odd): col = BAYER_B;
            (row_odd && !col_odd): col = BAYER_R;
            default:               col = BAYER_G;
        endcase

        pix = rgb[15:8];
        unique case (col)
            BAYER_R: pix = rgb[RGB_WIDTH-1 -: 8];
            BAYER_B: pix = rgb[7:0];
            default: pix = rgb[15:8];
        endcase
    end

endmodule

// File: rtl/rgb2raw_8.sv
// Re-mosaics an RGB pixel stream into packed raw8 Bayer words
// with line and frame gaps, as a sensor-less ISP test source.
module rgb2raw_8
    import rgb2raw_8_pkg::*;
#(
    parameter int LINE_LENGTH = 640,
    parameter int NUM_LINES   = 480,
    parameter int LINE_GAP    = 4,
    parameter int FRAME_GAP   = 16,
    parameter int RGB_WIDTH   = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [RGB_WIDTH-1:0] rgb_in,
    input  logic                 rgb_valid,
    output logic                 rgb_ready,
    output lane_raw_data_t       data_out,
    output logic                 data_valid,
    output logic                 line_start,
    output logic                 frame_end,
    output logic                 busy
);

    localparam int WW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int RW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int LW = $clog2(PIX_PER_WORD);
    localparam int GW = 16;

    rgb2raw_state_e state, state_nxt;

    logic [LW-1:0]  lane_cnt;
    logic [WW-1:0]  word_cnt;
    logic [RW-1:0]  row_cnt;
    logic [GW-1:0]  gap_cnt;
    lane_raw_data_t acc;
    lane_raw_data_t word_nxt;
    logic [7:0]     sample;

    logic hs;
    logic lane_last;
    logic word_last;
    logic row_last;
    logic gap_done;

    assign rgb_ready = (state == ST_LINE);
    assign busy      = (state != ST_IDLE);
    assign hs        = rgb_valid & rgb_ready;
    assign lane_last = (lane_cnt == LW'(PIX_PER_WORD - 1));
    assign word_last = (word_cnt == WW'(LINE_LENGTH - 1));
    assign row_last  = (row_cnt == RW'(NUM_LINES - 1));
    assign gap_done  = (gap_cnt == '0);
    assign word_nxt  = {acc[LANE_W-9:0], sample};

    // Word width is a multiple of two pixels, so column parity is lane parity.
    bayer_pick #(
        .RGB_WIDTH(RGB_WIDTH)
    ) u_pick (
        .row_odd(row_cnt[0]),
        .col_odd(lane_cnt[0]),
        .rgb    (rgb_in),
        .pix    (sample)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_LINE;
            end
            ST_LINE: begin
                if (hs && lane_last && word_last) state_nxt = ST_LGAP;
            end
            ST_LGAP: begin
                if (gap_done) begin
                    if (!row_last)          state_nxt = ST_LINE;
                    else if (FRAME_GAP > 0) state_nxt = ST_FGAP;
                    else if (en)            state_nxt = ST_LINE;
                    else                    state_nxt = ST_IDLE;
                end
            end
            ST_FGAP: begin
                if (gap_done) state_nxt = en ? ST_LINE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lane_cnt   <= '0;
            word_cnt   <= '0;
            row_cnt    <= '0;
            gap_cnt    <= '0;
            acc        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            line_start <= 1'b0;
            frame_end  <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_valid <= 1'b0;
            line_start <= 1'b0;
            frame_end  <= 1'b0;

            if (hs) begin
                acc <= word_nxt;
                if (lane_last) begin
                    lane_cnt   <= '0;
                    data_out   <= word_nxt;
                    data_valid <= 1'b1;
                    line_start <= (word_cnt == '0);
                    frame_end  <= word_last && row_last;
                    word_cnt   <= word_last ? '0 : word_cnt + WW'(1);
                end else begin
                    lane_cnt <= lane_cnt + LW'(1);
                end
            end

            if (state_nxt == ST_LGAP && state != ST_LGAP)
                gap_cnt <= GW'(LINE_GAP - 1);
            else if (state_nxt == ST_FGAP && state != ST_FGAP)
                gap_cnt <= GW'(FRAME_GAP - 1);
            else if (!gap_done)
                gap_cnt <= gap_cnt - GW'(1);

            if (state == ST_LGAP && gap_done)
                row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        end
    end

endmodule

// File: tb/tb_rgb2raw_8.sv
// Directed bench for rgb2raw_8: small 2-lane frame, 4 words x 2 lines.
// Flat, ramp, stalled ramp and mid-line reset scenarios.
module tb_rgb2raw_8;
    import rgb2raw_8_pkg::*;

    localparam int LL    = 4;
    localparam int NL    = 2;
    localparam int LG    = 4;
    localparam int FG    = 3;
    localparam int PPW   = 2;
    localparam int NPIX  = LL * NL * PPW;
    localparam int NWORD = LL * NL;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [23:0]    rgb_in = '0;
    logic           rgb_valid = 1'b0;
    logic           rgb_ready;
    lane_raw_data_t data_out;
    logic           data_valid;
    logic           line_start;
    logic           frame_end;
    logic           busy;

    always #5 clk = ~clk;

    rgb2raw_8 #(
        .LINE_LENGTH(LL),
        .NUM_LINES  (NL),
        .LINE_GAP   (LG),
        .FRAME_GAP  (FG),
        .RGB_WIDTH  (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rgb_in    (rgb_in),
        .rgb_valid (rgb_valid),
        .rgb_ready (rgb_ready),
        .data_out  (data_out),
        .data_valid(data_valid),
        .line_start(line_start),
        .frame_end (frame_end),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix_val(input int mode, input int idx);
        logic [7:0] i8;
        i8 = idx[7:0];
        if (mode == 0) return 24'h102030;
        return {8'h80 + i8, i8, 8'h40 + i8};
    endfunction

    function automatic logic [7:0] ref_sample(input int idx);
        int r, c;
        logic [23:0] p;
        r = (idx / (PPW * LL)) % NL;
        c = idx % (PPW * LL);
        p = pix_val(1, idx);
        if (r % 2 == 0) return (c % 2 == 0) ? p[15:8] : p[7:0];
        return (c % 2 == 0) ? p[23:16] : p[15:8];
    endfunction

    function automatic logic [15:0] ref_word(input int w);
        return {ref_sample(2 * w), ref_sample(2 * w + 1)};
    endfunction

    logic [15:0] wq[$];
    bit          lsq[$];
    bit          feq[$];
    int          runs[$];
    logic [15:0] ref_q[$];
    int          run = 0;
    bit          hs_last = 1'b0;

    // Monitor samples 2 time units after each falling edge.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            hs_last = 1'b0;
            run = 0;
        end else begin
            if (data_valid) begin
                check("dv_latency", 32'(hs_last), 32'd1);
                wq.push_back(data_out);
                lsq.push_back(line_start);
                feq.push_back(frame_end);
            end else if (line_start || frame_end) begin
                check("pulse_no_dv", {30'd0, line_start, frame_end}, 32'd0);
            end
            if (busy && !rgb_ready) begin
                run++;
            end else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
            hs_last = rgb_valid && rgb_ready;
        end
    end

    task automatic drive(input int mode, input bit stall, input int npix);
        int idx, cyc;
        bit v;
        idx = 0;
        cyc = 0;
        while (idx < npix && cyc < 400) begin
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rgb_valid = v;
            rgb_in = pix_val(mode, idx);
            if (v && rgb_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        rgb_valid = 1'b0;
        if (idx < npix) check("drive_timeout", idx, npix);
    endtask

    task automatic start_frame(input int mode, input bit stall, input int npix);
        wq.delete();
        lsq.delete();
        feq.delete();
        runs.delete();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        drive(mode, stall, npix);
    endtask

    task automatic run_frame(input int mode, input bit stall);
        int cnt;
        start_frame(mode, stall, NPIX);
        cnt = 0;
        while (busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic cmp_frame(input int mode);
        logic [15:0] expw;
        int nfe;
        check("n_words", wq.size(), NWORD);
        nfe = 0;
        for (int w = 0; w < NWORD; w++) begin
            if (w < wq.size()) begin
                if (mode == 0) expw = (w < LL) ? 16'h2030 : 16'h1020;
                else           expw = ref_word(w);
                check($sformatf("word%0d", w), wq[w], expw);
                check($sformatf("ls%0d", w), 32'(lsq[w]), 32'(w % LL == 0));
                if (feq[w]) nfe++;
            end
        end
        if (wq.size() == NWORD) check("fe_last", 32'(feq[NWORD-1]), 32'd1);
        check("fe_count", nfe, 1);
        check("n_gaps", runs.size(), 2);
        if (runs.size() > 0) check("line_gap", runs[0], LG);
        if (runs.size() > 1) check("frame_gap", runs[1], LG + FG);
    endtask

    task automatic chk_outputs_zero(input string tag);
        check({tag, "_dout"}, data_out, 32'd0);
        check({tag, "_dv"}, 32'(data_valid), 32'd0);
        check({tag, "_ls"}, 32'(line_start), 32'd0);
        check({tag, "_fe"}, 32'(frame_end), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rdy"}, 32'(rgb_ready), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_outputs_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_outputs_zero("idle");

        run_frame(0, 1'b0);
        cmp_frame(0);

        run_frame(1, 1'b0);
        cmp_frame(1);
        if (wq.size() > 4) begin
            check("ramp_w0", wq[0], 16'h0041);
            check("ramp_w4", wq[4], 16'h8809);
        end
        ref_q = wq;

        run_frame(1, 1'b1);
        cmp_frame(1);
        for (int w = 0; w < ref_q.size(); w++)
            if (w < wq.size()) check($sformatf("stall_eq%0d", w), wq[w], ref_q[w]);

        // Reset lands with one pixel of row 1 word 2 already accepted.
        start_frame(1, 1'b0, LL * PPW + 2 * PPW + 1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1, 1'b0);
        cmp_frame(1);
        if (wq.size() > 0) check("restart_w0", wq[0], 16'h0041);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
